// File: rtl/jk_excitation_sequencer_pkg.sv
// Shared types and helpers for the JK excitation sequencer.
package jk_excitation_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_e;

    // Check pipe depth: drive registered, bank captures, then compare.
    localparam int CHK_STAGES = 2;

    // Per-bit JK excitation that moves a flop from c to t, returned as {j, k}.
    // Don't-care halves are driven to 0 so the bank only sees the minimal drive.
    function automatic logic [1:0] jk_excite(input logic c, input logic t);
        return c ? {1'b0, ~t} : {t, 1'b0};
    endfunction

endpackage

// File: rtl/jk_excitation_sequencer_table.sv
// Target-state table: DEPTH x WIDTH register file, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module jk_seq_table #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Write port.
    always_ff @(posedge Clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Drives J/K excitation to an external JK flip-flop bank, stepping through a
// programmable table of target states, and checks the bank's Q readback
// against a mirror of the state it should hold.
module jk_excitation_sequencer
    import jk_excitation_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [AW:0]      length,
    input  logic             loop,
    input  logic             stop,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [WIDTH-1:0] state_mirror
);

    seq_state_e                       state;
    logic [AW-1:0]                    index;
    logic [AW:0]                      len_r;
    logic                             loop_r;
    logic                             stop_seen;
    logic [WIDTH-1:0]                 tgt;
    logic [WIDTH-1:0]                 j_next;
    logic [WIDTH-1:0]                 k_next;
    logic                             start_ok;
    logic                             last;
    logic                             drive;
    logic [CHK_STAGES-1:0]            vld_pipe;
    logic [CHK_STAGES-1:0][WIDTH-1:0] exp_pipe;

    jk_seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .Clock (Clock),
        .we    (load_en && (state == ST_IDLE)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (index),
        .rdata (tgt)
    );

    assign start_ok = (state == ST_IDLE) && start && (length != '0);
    assign last     = ({1'b0, index} == (len_r - (AW+1)'(1)));
    assign drive    = (state == ST_PRESET) || (state == ST_RUN);

    // Excitation from the mirrored present state to the current table target.
    always_comb begin
        j_next = '0;
        k_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_next[i], k_next[i]} = jk_excite(state_mirror[i], tgt[i]);
        end
    end

    // Sequencer FSM with registered J/K, mirror, busy and done.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state        <= ST_IDLE;
            index        <= '0;
            len_r        <= '0;
            loop_r       <= 1'b0;
            stop_seen    <= 1'b0;
            J            <= '0;
            K            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            state_mirror <= '0;
        end else begin
            J    <= '0;
            K    <= '0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state     <= ST_PRESET;
                            len_r     <= length;
                            loop_r    <= loop;
                            stop_seen <= 1'b0;
                        end
                    end
                end
                ST_PRESET: begin
                    // Clear the whole bank so the run starts from a known state.
                    K            <= '1;
                    state_mirror <= '0;
                    index        <= '0;
                    state        <= ST_RUN;
                    if (loop_r && stop) stop_seen <= 1'b1;
                end
                ST_RUN: begin
                    J            <= j_next;
                    K            <= k_next;
                    state_mirror <= tgt;
                    if (loop_r && stop) stop_seen <= 1'b1;
                    if (last) begin
                        // A stop arriving in the wrap cycle itself also ends the run.
                        if (loop_r && !(stop_seen || stop)) index <= '0;
                        else                                state <= ST_DRAIN;
                    end else begin
                        index <= index + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last in-flight check retires at this same edge.
                    if (!vld_pipe[0]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Readback check: expected state follows each drive two cycles later.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            vld_pipe <= '0;
            exp_pipe <= '0;
            mismatch <= 1'b0;
        end else begin
            vld_pipe[0] <= drive;
            exp_pipe[0] <= (state == ST_RUN) ? tgt : '0;
            vld_pipe[1] <= vld_pipe[0];
            exp_pipe[1] <= exp_pipe[0];
            if (start_ok)                               mismatch <= 1'b0;
            else if (vld_pipe[1] && (q_fb != exp_pipe[1])) mismatch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Directed bench for jk_excitation_sequencer with a behavioural JK bank.
module tb_jk_excitation_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             Clock = 1'b0;
    logic             Clear;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [AW:0]      length;
    logic             loop;
    logic             stop;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] q_fb;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [WIDTH-1:0] state_mirror;
    logic [WIDTH-1:0] bank;
    logic [WIDTH-1:0] fault;

    int checks = 0;
    int errors = 0;

    jk_excitation_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .Clear        (Clear),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .length       (length),
        .loop         (loop),
        .stop         (stop),
        .J            (J),
        .K            (K),
        .q_fb         (q_fb),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .state_mirror (state_mirror)
    );

    always #5 Clock = ~Clock;

    // External JK bank: Q+ = J & ~Q | ~K & Q.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) bank <= '0;
        else        bank <= (J & ~bank) | (~K & bank);
    end

    assign q_fb = bank | fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                        input logic eb, input logic ed);
        tick;
        chk({tag, ".J"},    32'(J),    32'(ej));
        chk({tag, ".K"},    32'(K),    32'(ek));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick;
        load_en   = 1'b0;
    endtask

    initial begin
        Clear = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; length = '0; loop = 1'b0; stop = 1'b0; fault = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst.J", 32'(J), 32'h0);
        chk("rst.K", 32'(K), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.mismatch", 32'(mismatch), 32'h0);
        chk("rst.mirror", 32'(state_mirror), 32'h0);
        Clear = 1'b1;
        tick;

        // Plain run over {5,A,F,0}
        load(3'd0, 4'h5); load(3'd1, 4'hA); load(3'd2, 4'hF); load(3'd3, 4'h0);
        start = 1'b1; length = 4'd4; loop = 1'b0;
        step("p0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("p1", 4'h0, 4'hF, 1'b1, 1'b0);
        step("p2", 4'h5, 4'h0, 1'b1, 1'b0);
        chk("p2.q", 32'(q_fb), 32'h0);
        chk("p2.mirror", 32'(state_mirror), 32'h5);
        step("p3", 4'hA, 4'h5, 1'b1, 1'b0);
        chk("p3.q", 32'(q_fb), 32'h5);
        step("p4", 4'h5, 4'h0, 1'b1, 1'b0);
        chk("p4.q", 32'(q_fb), 32'hA);
        step("p5", 4'h0, 4'hF, 1'b1, 1'b0);
        chk("p5.q", 32'(q_fb), 32'hF);
        step("p6", 4'h0, 4'h0, 1'b1, 1'b0);
        chk("p6.q", 32'(q_fb), 32'h0);
        step("p7", 4'h0, 4'h0, 1'b0, 1'b1);
        chk("p7.mismatch", 32'(mismatch), 32'h0);
        step("p8", 4'h0, 4'h0, 1'b0, 1'b0);

        // Looping run over {3,C} with stop mid-run
        load(3'd0, 4'h3); load(3'd1, 4'hC);
        start = 1'b1; length = 4'd2; loop = 1'b1;
        step("l0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("l1", 4'h0, 4'hF, 1'b1, 1'b0);
        step("l2", 4'h3, 4'h0, 1'b1, 1'b0);
        step("l3", 4'hC, 4'h3, 1'b1, 1'b0);
        stop = 1'b1;
        step("l4", 4'h3, 4'hC, 1'b1, 1'b0);
        stop = 1'b0;
        step("l5", 4'hC, 4'h3, 1'b1, 1'b0);
        chk("l5.mirror", 32'(state_mirror), 32'hC);
        step("l6", 4'h0, 4'h0, 1'b1, 1'b0);
        step("l7", 4'h0, 4'h0, 1'b0, 1'b1);
        step("l8", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("l8.mismatch", 32'(mismatch), 32'h0);
        loop = 1'b0;

        // length = 0: busy one cycle, then done, no drive
        start = 1'b1; length = 4'd0;
        step("z0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("z1", 4'h0, 4'h0, 1'b0, 1'b1);
        step("z2", 4'h0, 4'h0, 1'b0, 1'b0);

        // Reset during entry 2 of a run over {3,C,F,0}
        start = 1'b1; length = 4'd4;
        step("r0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("r1", 4'h0, 4'hF, 1'b1, 1'b0);
        step("r2", 4'h3, 4'h0, 1'b1, 1'b0);
        step("r3", 4'hC, 4'h3, 1'b1, 1'b0);
        step("r4", 4'h3, 4'h0, 1'b1, 1'b0);
        Clear = 1'b0;
        #1;
        chk("rm.J", 32'(J), 32'h0);
        chk("rm.K", 32'(K), 32'h0);
        chk("rm.busy", 32'(busy), 32'h0);
        chk("rm.mirror", 32'(state_mirror), 32'h0);
        tick;
        Clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rm.nodone", 32'(done), 32'h0);
        end

        // Rerun; start and load_en while in RUN must be ignored
        start = 1'b1; length = 4'd4;
        step("i0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("i1", 4'h0, 4'hF, 1'b1, 1'b0);
        start = 1'b1; length = 4'd0; load_en = 1'b1; load_addr = 3'd3; load_data = 4'h5;
        step("i2", 4'h3, 4'h0, 1'b1, 1'b0);
        start = 1'b0; load_en = 1'b0;
        step("i3", 4'hC, 4'h3, 1'b1, 1'b0);
        step("i4", 4'h3, 4'h0, 1'b1, 1'b0);
        step("i5", 4'h0, 4'hF, 1'b1, 1'b0);
        chk("i5.mirror", 32'(state_mirror), 32'h0);
        step("i6", 4'h0, 4'h0, 1'b1, 1'b0);
        chk("i6.q", 32'(q_fb), 32'h0);
        step("i7", 4'h0, 4'h0, 1'b0, 1'b1);
        chk("i7.mismatch", 32'(mismatch), 32'h0);

        // Fault: bit 0 of q_fb stuck high while entry 0 (=0) is read back
        load(3'd0, 4'h0);
        start = 1'b1; length = 4'd1;
        step("f0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        step("f1", 4'h0, 4'hF, 1'b1, 1'b0);
        step("f2", 4'h0, 4'h0, 1'b1, 1'b0);
        step("f3", 4'h0, 4'h0, 1'b1, 1'b0);
        chk("f3.mismatch", 32'(mismatch), 32'h0);
        fault = 4'h1;
        step("f4", 4'h0, 4'h0, 1'b0, 1'b1);
        chk("f4.mismatch", 32'(mismatch), 32'h1);
        fault = 4'h0;
        step("f5", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("f5.mismatch", 32'(mismatch), 32'h1);
        tick;
        chk("f6.mismatch", 32'(mismatch), 32'h1);
        start = 1'b1;
        step("g0", 4'h0, 4'h0, 1'b1, 1'b0);
        start = 1'b0;
        chk("g0.mismatch", 32'(mismatch), 32'h0);
        step("g1", 4'h0, 4'hF, 1'b1, 1'b0);
        step("g2", 4'h0, 4'h0, 1'b1, 1'b0);
        step("g3", 4'h0, 4'h0, 1'b1, 1'b0);
        step("g4", 4'h0, 4'h0, 1'b0, 1'b1);
        chk("g4.mismatch", 32'(mismatch), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
